// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter slice.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef enum logic {
        REQ_HOST = 1'b0,
        REQ_CPU  = 1'b1
    } req_e;

    // Round-robin pick: with both eligible the one not granted last wins.
    function automatic req_e rr_pick(input logic host_elig,
                                     input logic cpu_elig,
                                     input req_e last);
        req_e pick;
        if (host_elig && cpu_elig) begin
            if (last == REQ_HOST) begin
                pick = REQ_CPU;
            end else begin
                pick = REQ_HOST;
            end
        end else if (cpu_elig) begin
            pick = REQ_CPU;
        end else begin
            pick = REQ_HOST;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Memory-clear sweep sequencer: walks every address once after a start pulse.
// busy is registered one cycle behind the counter so that it lines up with
// the registered memory write the top issues for each counter value.
module mem_clear_seq
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic              active_q, active_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Next-state for the sweep counter and its active flag.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        busy_d   = active_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            cnt_d = cnt_q + ONE;
            if (cnt_q == '1) begin
                active_d = 1'b0;
            end
        end
    end

    // Sweep state registers; reset abandons any sweep in flight.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign addr = cnt_q;
    assign done = active_q && (cnt_q == '1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port program/data memory between the host load/debug
// port and the CPU, with registered grants and a two-entry read-tag pipe.
// Optional feature: define MEM_ARB_CLEAR_EN to build the hardware
// memory-clear sweep (CLEAR state, clear counter, busy). Without it clr_mem
// is ignored and busy is tied low.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              clr_mem,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e            state_q, state_d;
    req_e              last_grant_q, last_grant_d;
    req_e              winner;
    logic              host_elig, cpu_elig;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              host_ack_q, host_ack_d;
    logic              cpu_ack_q, cpu_ack_d;

    // Read-tag pipe: stage 1 marks a read on the memory port, stage 2 is the
    // cycle its data comes back from the synchronous memory.
    logic              rd_vld_q, rd_vld_d;
    req_e              rd_tag_q, rd_tag_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;

    logic              clr_req;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_done;

`ifdef MEM_ARB_CLEAR_EN
    logic clr_start;
    logic clr_busy;

    assign clr_req   = clr_mem;
    assign clr_start = (state_q == ST_ARB) && clr_mem;

    mem_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .main_clk (main_clk),
        .reset    (reset),
        .start    (clr_start),
        .busy     (clr_busy),
        .addr     (clr_addr),
        .done     (clr_done)
    );

    assign busy = clr_busy;
`else
    logic unused_clr_mem;

    assign unused_clr_mem = clr_mem;
    assign clr_req        = 1'b0;
    assign clr_addr       = '0;
    assign clr_done       = 1'b0;
    assign busy           = 1'b0;
`endif

    assign host_elig = host_req;
    assign cpu_elig  = cpu_req & cpu_en;

    // Arbitration / clear sequencing and next values of the output registers.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        host_ack_d   = 1'b0;
        cpu_ack_d    = 1'b0;
        rd_vld_d     = 1'b0;
        rd_tag_d     = rd_tag_q;
        winner       = rr_pick(host_elig, cpu_elig, last_grant_q);

        case (state_q)
            ST_ARB: begin
                if (clr_req) begin
                    // Clear outranks every request; nothing is granted now.
                    state_d = ST_CLEAR;
                end else if (host_elig || cpu_elig) begin
                    mem_en_d     = 1'b1;
                    last_grant_d = winner;
                    rd_tag_d     = winner;
                    if (winner == REQ_CPU) begin
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        cpu_ack_d   = 1'b1;
                        rd_vld_d    = ~cpu_we;
                    end else begin
                        mem_we_d    = host_we;
                        mem_addr_d  = host_addr;
                        mem_wdata_d = host_wdata;
                        host_ack_d  = 1'b1;
                        rd_vld_d    = ~host_we;
                    end
                end
            end
            ST_CLEAR: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = clr_addr;
                mem_wdata_d = '0;
                if (clr_done) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        host_rvalid_d = rd_vld_q && (rd_tag_q == REQ_HOST);
        cpu_rvalid_d  = rd_vld_q && (rd_tag_q == REQ_CPU);
    end

    // State, grant history, memory-port outputs and the read-tag pipe.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            state_q       <= ST_ARB;
            last_grant_q  <= REQ_HOST;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            host_ack_q    <= 1'b0;
            cpu_ack_q     <= 1'b0;
            rd_vld_q      <= 1'b0;
            rd_tag_q      <= REQ_HOST;
            host_rvalid_q <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            host_ack_q    <= host_ack_d;
            cpu_ack_q     <= cpu_ack_d;
            rd_vld_q      <= rd_vld_d;
            rd_tag_q      <= rd_tag_d;
            host_rvalid_q <= host_rvalid_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign host_ack    = host_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign host_rvalid = host_rvalid_q;
    assign cpu_rvalid  = cpu_rvalid_q;

    // Read data comes straight from the memory, qualified by the returning tag.
    assign host_rdata  = host_rvalid_q ? mem_rdata : '0;
    assign cpu_rdata   = cpu_rvalid_q  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of per-cycle vectors with
// a scoreboard for acks/memory outputs and read responses, plus hand-written
// sequences for CPU masking, the clear sweep and reset during a sweep.
module tb_mem_port_arbiter;

    logic        main_clk;
    logic        reset;
    logic        cpu_en;
    logic        clr_mem;
    logic        host_req, host_we;
    logic [11:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_ack, host_rvalid;
    logic [31:0] host_rdata;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter dut (
        .main_clk    (main_clk),
        .reset       (reset),
        .cpu_en      (cpu_en),
        .clr_mem     (clr_mem),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    // Synchronous single-port memory model.
    logic        preload;
    logic [31:0] mem_model [0:4095];
    always @(posedge main_clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) mem_model[i] <= 32'h0;
            mem_model[1] <= 32'hFFFF_FFFA;
            mem_rdata    <= 32'h0;
        end else if (mem_en === 1'b1) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    typedef struct {
        logic        hreq, hwe;
        logic [11:0] haddr;
        logic [31:0] hwd;
        logic        creq, cwe;
        logic [11:0] caddr;
        logic [31:0] cwd;
        logic        cen, clr;
        logic        e_hack, e_cack, e_en, e_we;
        logic [11:0] e_addr;
        logic [31:0] e_wd;
        int          e_rd;      // 0 none, 1 host read returns, 2 cpu read returns
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        int   due;
        vec_t v;
    } gexp_t;

    typedef struct {
        int          due;
        int          tag;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    vec_t  tbl[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    logic  sb_on    = 1'b0;

    function automatic vec_t mk(input logic hreq, input logic hwe,
                                input logic [11:0] haddr, input logic [31:0] hwd,
                                input logic creq, input logic cwe,
                                input logic [11:0] caddr, input logic [31:0] cwd,
                                input logic cen, input logic clr,
                                input logic eh, input logic ec,
                                input logic een, input logic ewe,
                                input logic [11:0] ea, input logic [31:0] ew,
                                input int erd, input logic [31:0] erdata);
        vec_t v;
        v.hreq = hreq;  v.hwe = hwe;  v.haddr = haddr;  v.hwd = hwd;
        v.creq = creq;  v.cwe = cwe;  v.caddr = caddr;  v.cwd = cwd;
        v.cen  = cen;   v.clr = clr;
        v.e_hack = eh;  v.e_cack = ec; v.e_en = een;    v.e_we = ewe;
        v.e_addr = ea;  v.e_wd = ew;   v.e_rd = erd;    v.e_rdata = erdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_due();
        gexp_t g;
        rexp_t r;
        if (!sb_on) return;
        if (gq.size() > 0 && gq[0].due == cyc) begin
            g = gq.pop_front();
            chk("host_ack", {31'b0, host_ack}, {31'b0, g.v.e_hack});
            chk("cpu_ack",  {31'b0, cpu_ack},  {31'b0, g.v.e_cack});
            chk("mem_en",   {31'b0, mem_en},   {31'b0, g.v.e_en});
            if (g.v.e_en) begin
                chk("mem_we",   {31'b0, mem_we}, {31'b0, g.v.e_we});
                chk("mem_addr", {20'b0, mem_addr}, {20'b0, g.v.e_addr});
                if (g.v.e_we) chk("mem_wdata", mem_wdata, g.v.e_wd);
            end
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.tag == 1) begin
                chk("host_rvalid", {31'b0, host_rvalid}, 32'd1);
                chk("cpu_rvalid_idle", {31'b0, cpu_rvalid}, 32'd0);
                chk("host_rdata", host_rdata, r.data);
            end else begin
                chk("cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
                chk("host_rvalid_idle", {31'b0, host_rvalid}, 32'd0);
                chk("cpu_rdata", cpu_rdata, r.data);
            end
        end else begin
            chk("host_rvalid_idle", {31'b0, host_rvalid}, 32'd0);
            chk("cpu_rvalid_idle",  {31'b0, cpu_rvalid},  32'd0);
        end
    endtask

    task automatic tick();
        @(posedge main_clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic drive(input vec_t v);
        gexp_t g;
        rexp_t r;
        host_req = v.hreq;  host_we = v.hwe;  host_addr = v.haddr;  host_wdata = v.hwd;
        cpu_req  = v.creq;  cpu_we  = v.cwe;  cpu_addr  = v.caddr;  cpu_wdata  = v.cwd;
        cpu_en   = v.cen;   clr_mem = v.clr;
        g.due = cyc + 1;
        g.v   = v;
        gq.push_back(g);
        if (v.e_rd != 0) begin
            r.due  = cyc + 2;
            r.tag  = v.e_rd;
            r.data = v.e_rdata;
            rq.push_back(r);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        int   n_busy;
        int   bad;
        int   exp_a;
        logic found;

        reset = 1'b1; preload = 1'b1;
        cpu_en = 1'b0; clr_mem = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        idle = mk(0,0,12'h0,32'h0, 0,0,12'h0,32'h0, 0,0, 0,0,0,0,12'h0,32'h0, 0,32'h0);

        tbl.push_back(mk(1,1,12'h000,32'h0000_0006, 0,0,12'h0,32'h0, 0,0,
                         1,0,1,1,12'h000,32'h0000_0006, 0,32'h0));
        tbl.push_back(mk(1,1,12'h004,32'h1C00_0003, 1,1,12'h3FF,32'h99, 0,0,
                         1,0,1,1,12'h004,32'h1C00_0003, 0,32'h0));
        tbl.push_back(idle);
        tbl.push_back(mk(1,0,12'h001,32'h0, 0,0,12'h0,32'h0, 0,0,
                         1,0,1,0,12'h001,32'h0, 1,32'hFFFF_FFFA));
        tbl.push_back(idle);
        for (int k = 0; k < 6; k++) begin
            logic even;
            even = (k % 2 == 0);
            tbl.push_back(mk(1,0,12'h000,32'h0, 1,0,12'h004,32'h0, 1,0,
                             ~even, even, 1, 0, even ? 12'h004 : 12'h000, 32'h0,
                             even ? 2 : 1, even ? 32'h1C00_0003 : 32'h0000_0006));
        end
        tbl.push_back(idle);
        tbl.push_back(mk(0,0,12'h0,32'h0, 1,1,12'h7FF,32'hDEAD_BEEF, 1,0,
                         0,1,1,1,12'h7FF,32'hDEAD_BEEF, 0,32'h0));
        tbl.push_back(mk(0,0,12'h0,32'h0, 1,0,12'h7FF,32'h0, 1,0,
                         0,1,1,0,12'h7FF,32'h0, 2,32'hDEAD_BEEF));
        tbl.push_back(mk(1,1,12'h123,32'hA5A5_A5A5, 1,0,12'h7FF,32'h0, 1,0,
                         1,0,1,1,12'h123,32'hA5A5_A5A5, 0,32'h0));
        tbl.push_back(mk(0,0,12'h0,32'h0, 1,0,12'h7FF,32'h0, 0,0,
                         0,0,0,0,12'h0,32'h0, 0,32'h0));
        tbl.push_back(idle);
        tbl.push_back(mk(1,0,12'h123,32'h0, 0,0,12'h0,32'h0, 0,0,
                         1,0,1,0,12'h123,32'h0, 1,32'hA5A5_A5A5));
        tbl.push_back(idle);
        tbl.push_back(idle);

        // Reset values.
        tick();
        tick();
        preload = 1'b0;
        chk("rst_host_ack",    {31'b0, host_ack},    32'd0);
        chk("rst_cpu_ack",     {31'b0, cpu_ack},     32'd0);
        chk("rst_host_rvalid", {31'b0, host_rvalid}, 32'd0);
        chk("rst_cpu_rvalid",  {31'b0, cpu_rvalid},  32'd0);
        chk("rst_mem_en",      {31'b0, mem_en},      32'd0);
        chk("rst_mem_we",      {31'b0, mem_we},      32'd0);
        chk("rst_busy",        {31'b0, busy},        32'd0);
        chk("rst_mem_addr",    {20'b0, mem_addr},    32'd0);
        chk("rst_mem_wdata",   mem_wdata,            32'd0);
        chk("rst_host_rdata",  host_rdata,           32'd0);
        chk("rst_cpu_rdata",   cpu_rdata,            32'd0);
        reset = 1'b0;
        sb_on = 1'b1;

        // Table-driven traffic.
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            tick();
        end

        // CPU masked by cpu_en for 10 cycles, then unmasked.
        for (int k = 0; k < 10; k++) begin
            drive(mk(0,0,12'h0,32'h0, 1,0,12'h004,32'h0, 0,0,
                     0,0,0,0,12'h0,32'h0, 0,32'h0));
            tick();
        end
        drive(mk(0,0,12'h0,32'h0, 1,0,12'h004,32'h0, 1,0,
                 0,1,1,0,12'h004,32'h0, 2,32'h1C00_0003));
        tick();
        drive(idle);
        tick();
        tick();
        tick();

`ifdef MEM_ARB_CLEAR_EN
        // Clear sweep with a host write pending.
        drive(mk(1,1,12'h055,32'h77, 0,0,12'h0,32'h0, 0,1,
                 0,0,0,0,12'h0,32'h0, 0,32'h0));
        tick();
        clr_mem = 1'b0;
        n_busy = 0; bad = 0; exp_a = 0; found = 1'b0;
        for (int i = 0; i < 4300; i++) begin
            tick();
            if (busy === 1'b1) begin
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h0 ||
                    mem_addr !== exp_a[11:0] || host_ack !== 1'b0) bad++;
                n_busy++;
                exp_a++;
            end else if (n_busy > 0) begin
                found = 1'b1;
                chk("ack_after_clear", {31'b0, host_ack}, 32'd1);
                chk("addr_after_clear", {20'b0, mem_addr}, 32'h055);
                host_req = 1'b0;
                break;
            end else if (host_ack !== 1'b0) begin
                bad++;
            end
        end
        chk("sweep_writes_bad", bad, 32'd0);
        chk("busy_len", n_busy, 32'd4096);
        chk("busy_fell", {31'b0, found}, 32'd1);
        host_req = 1'b0;
        tick();
        tick();
        chk("cleared_0",   mem_model[12'h000], 32'h0);
        chk("cleared_7ff", mem_model[12'h7FF], 32'h0);
        chk("cleared_fff", mem_model[12'hFFF], 32'h0);
        chk("post_clear_write", mem_model[12'h055], 32'h77);

        // Reset in the middle of a sweep.
        clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (busy === 1'b1 && mem_addr === 12'd100) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("reached_addr_100", {31'b0, found}, 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_busy",   {31'b0, busy},   32'd0);
        chk("midrst_mem_en", {31'b0, mem_en}, 32'd0);
        reset = 1'b0;
        drive(mk(1,1,12'h200,32'h1234, 0,0,12'h0,32'h0, 0,0,
                 1,0,1,1,12'h200,32'h1234, 0,32'h0));
        tick();
        drive(idle);
        tick();
        chk("midrst_busy2", {31'b0, busy}, 32'd0);
        clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("restart_busy", {31'b0, found}, 32'd1);
        chk("restart_addr", {20'b0, mem_addr}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 4200; i++) begin
            tick();
            if (busy !== 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("restart_done", {31'b0, found}, 32'd1);
`else
        // clr_mem has no effect: the host write is granted normally.
        drive(mk(1,1,12'h055,32'h77, 0,0,12'h0,32'h0, 0,1,
                 1,0,1,1,12'h055,32'h77, 0,32'h0));
        tick();
        chk("noclr_busy", {31'b0, busy}, 32'd0);
        drive(idle);
        for (int i = 0; i < 5; i++) tick();
        chk("noclr_busy2", {31'b0, busy}, 32'd0);
        chk("noclr_mem0", mem_model[12'h000], 32'h0000_0006);
        chk("noclr_mem55", mem_model[12'h055], 32'h77);
`endif

        drive(idle);
        tick();
        tick();
        chk("sb_drained", gq.size() + rq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
